// File: rtl/rf_wb_stage.sv
// Writeback stage: selects a result source, extends load data, buffers one
// RF write under a valid/ack handshake. Optional forwarding port via RF_WB_FWD_EN.
module rf_wb_stage #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 5,
  parameter int N_SRC       = 4,
  parameter int SEL_W       = 2,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_wen,
  input  logic [ADDR_W-1:0]       in_waddr,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [N_SRC*DATA_W-1:0] in_src,
  input  logic [2:0]              in_ld_mode,
  output logic                    rf_we,
  output logic [ADDR_W-1:0]       rf_waddr,
  output logic [DATA_W-1:0]       rf_wdata,
  input  logic                    rf_ack,
  output logic                    err_sel,
  output logic [31:0]             commit_cnt,
  output logic                    fwd_valid,
  output logic [ADDR_W-1:0]       fwd_addr,
  output logic [DATA_W-1:0]       fwd_data
);

  localparam int SHW = $clog2(DATA_W) + 1;

  // Handshake: a request moves when in_valid & in_ready; an RF write
  // completes on the cycle rf_we & rf_ack, and the slot may refill in that same cycle.
  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_err_sel;
  logic [31:0]         r_commit_cnt;

  logic                w_accept, w_complete;
  logic                w_sel_legal, w_is_zero, w_eff_wen;
  logic [DATA_W-1:0]   w_src0, w_shl, w_ld_data, w_sel_data;
  logic [SHW-1:0]      w_shamt;

  // Load extension: shift the field to the top, then shift back arithmetically or logically.
  always_comb begin
    w_src0 = in_src[DATA_W-1:0];
    case (in_ld_mode[1:0])
      2'd0:    w_shamt = SHW'(DATA_W - 8);
      2'd1:    w_shamt = SHW'(DATA_W - 16);
      2'd2:    w_shamt = SHW'(DATA_W - 32);
      default: w_shamt = '0;
    endcase
    w_shl = w_src0 << w_shamt;
    if (in_ld_mode[2]) w_ld_data = $signed(w_shl) >>> w_shamt;
    else               w_ld_data = w_shl >> w_shamt;
  end

  always_comb begin
    w_sel_legal = (32'(in_sel) < N_SRC);
    w_sel_data  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (in_sel == SEL_W'(k)) begin
        if (k == 0) w_sel_data = w_ld_data;
        else        w_sel_data = in_src[k*DATA_W +: DATA_W];
      end
    end
    w_is_zero = (ZERO_REG_EN != 0) && (in_waddr == '0);
    w_eff_wen = in_wen & ~w_is_zero & w_sel_legal;
  end

  assign rf_we      = (r_state == S_FULL);
  assign w_complete = rf_we & rf_ack;
  // Held low during reset so nothing is taken while the stage is cleared.
  assign in_ready   = rst_n & ((r_state == S_EMPTY) | w_complete);
  assign w_accept   = in_valid & in_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept)        w_state_nxt = w_eff_wen ? S_FULL : S_EMPTY;
    else if (w_complete) w_state_nxt = S_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_err_sel    <= 1'b0;
      r_commit_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && w_eff_wen) begin
        r_waddr <= in_waddr;
        r_wdata <= w_sel_data;
      end
      if (w_accept && !w_sel_legal) r_err_sel <= 1'b1;
      if (w_complete) r_commit_cnt <= r_commit_cnt + 32'd1;
    end
  end

  assign rf_waddr   = r_waddr;
  assign rf_wdata   = r_wdata;
  assign err_sel    = r_err_sel;
  assign commit_cnt = r_commit_cnt;

`ifdef RF_WB_FWD_EN
  assign fwd_valid = rf_we;
  assign fwd_addr  = r_waddr;
  assign fwd_data  = r_wdata;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_rf_wb_stage.sv
// Directed bench for rf_wb_stage with N_SRC = 3 so select 3 is illegal.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rf_wb_stage;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int N_SRC  = 3;
  localparam int SEL_W  = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_wen;
  logic [ADDR_W-1:0]       in_waddr;
  logic [SEL_W-1:0]        in_sel;
  logic [N_SRC*DATA_W-1:0] in_src;
  logic [2:0]              in_ld_mode;
  logic                    rf_we;
  logic [ADDR_W-1:0]       rf_waddr;
  logic [DATA_W-1:0]       rf_wdata;
  logic                    rf_ack;
  logic                    err_sel;
  logic [31:0]             commit_cnt;
  logic                    fwd_valid;
  logic [ADDR_W-1:0]       fwd_addr;
  logic [DATA_W-1:0]       fwd_data;

  int n_checks = 0;
  int n_err    = 0;

  rf_wb_stage #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_SRC(N_SRC), .SEL_W(SEL_W), .ZERO_REG_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_waddr(in_waddr), .in_sel(in_sel), .in_src(in_src), .in_ld_mode(in_ld_mode),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ack(rf_ack),
    .err_sel(err_sel), .commit_cnt(commit_cnt),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Driver: present a request at a falling edge, hold it across one rising edge.
  task automatic present(input logic [1:0] sel, input logic [4:0] waddr,
                         input logic [63:0] s0, input logic [63:0] s1,
                         input logic [63:0] s2, input logic [2:0] mode);
    in_valid   = 1'b1;
    in_wen     = 1'b1;
    in_sel     = sel;
    in_waddr   = waddr;
    in_src     = {s2, s1, s0};
    in_ld_mode = mode;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] waddr,
                       input logic [63:0] s0, input logic [63:0] s1,
                       input logic [63:0] s2, input logic [2:0] mode);
    present(sel, waddr, s0, s1, s2, mode);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [63:0] ld_src;
  logic [2:0]  ld_mode_t [6];
  logic [63:0] ld_exp_t  [6];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_wen = 1'b0; in_waddr = '0; in_sel = '0;
    in_src = '0; in_ld_mode = '0; rf_ack = 1'b0;
    ld_src = 64'h0123_4567_89AB_CD80;
    ld_mode_t[0] = 3'b100; ld_exp_t[0] = 64'hFFFF_FFFF_FFFF_FF80;
    ld_mode_t[1] = 3'b001; ld_exp_t[1] = 64'h0000_0000_0000_CD80;
    ld_mode_t[2] = 3'b000; ld_exp_t[2] = 64'h0000_0000_0000_0080;
    ld_mode_t[3] = 3'b101; ld_exp_t[3] = 64'hFFFF_FFFF_FFFF_CD80;
    ld_mode_t[4] = 3'b110; ld_exp_t[4] = 64'hFFFF_FFFF_89AB_CD80;
    ld_mode_t[5] = 3'b111; ld_exp_t[5] = 64'h0123_4567_89AB_CD80;

    // Reset state
    #12;
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", rf_wdata, 64'd0);
    chk("rst_err", 64'(err_sel), 64'd0);
    chk("rst_cnt", 64'(commit_cnt), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", 64'(in_ready), 64'd1);

    // Source 1 pass-through with rf_ack held high
    @(negedge clk);
    rf_ack = 1'b1;
    issue(2'd1, 5'd7, 64'h0, 64'h0000_0000_DEAD_BEEF, 64'h0, 3'b000);
    chk("s1_we", 64'(rf_we), 64'd1);
    chk("s1_waddr", 64'(rf_waddr), 64'd7);
    chk("s1_wdata", rf_wdata, 64'h0000_0000_DEAD_BEEF);
    @(negedge clk);
    chk("s1_cnt", 64'(commit_cnt), 64'd1);
    chk("s1_we_drop", 64'(rf_we), 64'd0);

    // Load extension table, one write each
    for (int i = 0; i < 6; i++) begin
      issue(2'd0, 5'd3, ld_src, 64'h0, 64'h0, ld_mode_t[i]);
      chk($sformatf("ld_mode%0d", i), rf_wdata, ld_exp_t[i]);
      @(negedge clk);
    end
    chk("ld_cnt", 64'(commit_cnt), 64'd7);

    // Source 2 ignores load mode
    issue(2'd2, 5'd4, ld_src, 64'h0, 64'h0000_0000_0000_0081, 3'b100);
    chk("s2_wdata", rf_wdata, 64'h0000_0000_0000_0081);
    @(negedge clk);

    // Backpressure: three back-to-back requests, rf_ack low for 4 cycles
    do_reset();
    rf_ack = 1'b0;
    issue(2'd1, 5'd1, 64'h0, 64'hA1, 64'h0, 3'b000);
    present(2'd1, 5'd2, 64'h0, 64'hA2, 64'h0, 3'b000);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("bp_ready%0d", c), 64'(in_ready), 64'd0);
      chk($sformatf("bp_hold%0d", c), rf_wdata, 64'hA1);
      @(negedge clk);
    end
    chk("bp_we_held", 64'(rf_we), 64'd1);
    rf_ack = 1'b1;
    @(negedge clk);
    chk("bp_w2", rf_wdata, 64'hA2);
    chk("bp_w2_we", 64'(rf_we), 64'd1);
    chk("bp_cnt1", 64'(commit_cnt), 64'd1);
    present(2'd1, 5'd3, 64'h0, 64'hA3, 64'h0, 3'b000);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_w3", rf_wdata, 64'hA3);
    chk("bp_w3_addr", 64'(rf_waddr), 64'd3);
    @(negedge clk);
    chk("bp_cnt3", 64'(commit_cnt), 64'd3);
    chk("bp_empty", 64'(rf_we), 64'd0);

    // Zero register discarded
    issue(2'd1, 5'd0, 64'h0, 64'h1234, 64'h0, 3'b000);
    chk("zr_we0", 64'(rf_we), 64'd0);
    @(negedge clk);
    chk("zr_we1", 64'(rf_we), 64'd0);
    chk("zr_cnt", 64'(commit_cnt), 64'd3);

    // Illegal select: no write, sticky error
    issue(2'd3, 5'd5, 64'h0, 64'h0, 64'h0, 3'b000);
    chk("ill_we", 64'(rf_we), 64'd0);
    chk("ill_err", 64'(err_sel), 64'd1);
    issue(2'd1, 5'd6, 64'h0, 64'h66, 64'h0, 3'b000);
    chk("ill_next_we", 64'(rf_we), 64'd1);
    @(negedge clk);
    chk("ill_err_sticky", 64'(err_sel), 64'd1);
    chk("ill_cnt", 64'(commit_cnt), 64'd4);

    // Reset mid-operation while stalled
    rf_ack = 1'b0;
    issue(2'd1, 5'd8, 64'h0, 64'h88, 64'h0, 3'b000);
    chk("mr_we_pre", 64'(rf_we), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_we", 64'(rf_we), 64'd0);
    chk("mr_cnt", 64'(commit_cnt), 64'd0);
    chk("mr_ready", 64'(in_ready), 64'd0);
    chk("mr_err", 64'(err_sel), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rf_ack = 1'b1;
    #1 chk("mr_ready_rel", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("mr_no_reissue", 64'(rf_we), 64'd0);
    chk("mr_cnt_after", 64'(commit_cnt), 64'd0);

    // Forwarding port while stalled
    rf_ack = 1'b0;
    issue(2'd1, 5'd9, 64'h0, 64'h55, 64'h0, 3'b000);
    @(negedge clk);
`ifdef RF_WB_FWD_EN
    chk("fwd_valid", 64'(fwd_valid), 64'd1);
    chk("fwd_addr", 64'(fwd_addr), 64'd9);
    chk("fwd_data", fwd_data, 64'h55);
`else
    chk("fwd_valid", 64'(fwd_valid), 64'd0);
    chk("fwd_addr", 64'(fwd_addr), 64'd0);
    chk("fwd_data", fwd_data, 64'h0);
`endif
    chk("fwd_stall_we", 64'(rf_we), 64'd1);
    rf_ack = 1'b1;
    @(negedge clk);
    chk("fwd_drain_cnt", 64'(commit_cnt), 64'd1);
    chk("fwd_valid_off", 64'(fwd_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_stage.md
Name: rf_wb_stage

Overview:
- Parametrised writeback stage for the 64-bit pipelined core. Successor to the fixed 3-source writeback data mux.
- Selects one of N_SRC result sources using an encoded select, not priority opcode flags.
- Applies load-width extension to the memory source and registers the result in a one-entry output buffer.
- Drives the register-file write port under a valid/ack handshake, with sticky error reporting and a commit counter.

Parameters:
- DATA_W, 64: datapath width; must be a multiple of 8 and at least 32.
- ADDR_W, 5: register-file address width.
- N_SRC, 4: number of result sources. Source 0 is always memory load data.
- SEL_W, 2: width of the source select; must satisfy 2^SEL_W >= N_SRC.
- ZERO_REG_EN, 1: when 1, writes to register address 0 are discarded.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  WB request present
- in_ready  out  1  stage can accept request
- in_wen  in  1  request writes the RF
- in_waddr  in  ADDR_W  destination register
- in_sel  in  SEL_W  source index
- in_src  in  N_SRC*DATA_W  packed sources; source k occupies bits [k*DATA_W +: DATA_W]
- in_ld_mode  in  3  load extension: bit2 = signed, bits[1:0] = size (0 byte, 1 half, 2 word, 3 full)
- rf_we  out  1  RF write strobe
- rf_waddr  out  ADDR_W  RF write address
- rf_wdata  out  DATA_W  RF write data
- rf_ack  in  1  RF accepted the write this cycle
- err_sel  out  1  sticky: an illegal select was seen
- commit_cnt  out  32  count of completed RF writes
- fwd_valid  out  1  forwarding entry valid
- fwd_addr  out  ADDR_W  forwarding address
- fwd_data  out  DATA_W  forwarding data

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State goes to EMPTY.
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0, err_sel = 0, commit_cnt = 0.
  - fwd_valid = 0, fwd_addr = 0, fwd_data = 0.
  - in_ready is 1 as soon as rst_n returns to 1.
- States: EMPTY and FULL.
  - in_ready = (state == EMPTY) | (rf_ack & rf_we). A completing write and a new accept may occur in the same cycle.
  - Accept event = in_valid & in_ready. On accept, the buffer loads waddr, the computed data and the effective wen. Latency from accept to rf_we is 1 cycle.
  - Effective wen = in_wen & ~(ZERO_REG_EN & in_waddr == 0) & sel_legal.
  - An accepted request with effective wen = 0 is retired silently: state stays or becomes EMPTY, rf_we stays 0, and the counter is unchanged.
- Transitions:
  - EMPTY, accept with wen: go to FULL.
  - FULL, rf_ack without accept: go to EMPTY.
  - FULL, rf_ack with accept: reload and stay FULL (back-to-back writes).
  - FULL, no rf_ack: hold all outputs stable; in_ready = 0.
- Output rule: rf_we = (state == FULL). rf_waddr and rf_wdata come straight from the buffer registers.
- Data selection:
  - sel_legal = in_sel < N_SRC. An illegal select gives data 0, forces wen = 0 and sets err_sel, which clears only on reset.
  - Source 0 (memory): extract the low 8, 16 or 32 bits, or pass the full word, per size. Sign-extend when bit2 = 1, zero-extend otherwise.
  - Sources 1..N_SRC-1: passed through unmodified; in_ld_mode is ignored.
- commit_cnt increments by 1 on each cycle with rf_we & rf_ack, and wraps from 0xFFFFFFFF to 0.
- rf_ack while rf_we = 0 is ignored.
- Reset mid-transfer: the pending write is dropped and is never re-issued.

Optional Feature:
- Macro: RF_WB_FWD_EN.
- Defined:
  - fwd_valid = rf_we.
  - fwd_addr = rf_waddr and fwd_data = rf_wdata, combinationally, so decode can bypass a write that is pending or stalled.
- Undefined: fwd_valid, fwd_addr and fwd_data are tied to 0. No forwarding logic is synthesised.

Test Plan:
- Source 1 pass-through: in_sel = 1, src1 = 0x0000_0000_DEAD_BEEF, waddr = 7, rf_ack held 1 → next cycle rf_we = 1, rf_waddr = 7, rf_wdata = 0x0000_0000_DEAD_BEEF; commit_cnt becomes 1.
- Load sign extension:
  - in_sel = 0, src0 = 0x0123_4567_89AB_CD80, mode = 3'b100 (signed byte) → rf_wdata = 0xFFFF_FFFF_FFFF_FF80.
  - Same source with mode = 3'b001 (unsigned half) → 0x0000_0000_0000_CD80.
- Backpressure: issue 3 back-to-back requests with rf_ack = 0 for 4 cycles → in_ready = 0 and rf_wdata stays at request 1's value. After ack resumes, writes appear in order 1, 2, 3 on consecutive cycles and commit_cnt = 3.
- Zero-register and illegal select (N_SRC = 3):
  - Write to waddr 0 → rf_we never asserts.
  - in_sel = 3 → rf_we never asserts and err_sel = 1, sticky until rst_n is pulsed.
- Reset mid-operation: state FULL with rf_ack = 0, drop rst_n asynchronously between clock edges → rf_we = 0, commit_cnt = 0 and in_ready = 0 immediately. in_ready = 1 after release.
- RF_WB_FWD_EN on/off: while stalled in FULL with waddr = 9, data = 0x55 → fwd_valid = 1, fwd_addr = 9, fwd_data = 0x55 when the macro is defined, and all zero when it is undefined.
